// File: rtl/core_retire_unit_pkg.sv
// Shared types for the retire stage: ROB entry layout and the retire state enum.
// Entry widths are fixed here so every consumer of the ROB agrees on the layout.
package core_retire_unit_pkg;

  localparam int ROB_LEN = 16;
  localparam int PW      = $clog2(ROB_LEN);
  localparam int REGS    = 16;
  localparam int RW      = $clog2(REGS);
  localparam int DW      = 16;

  typedef struct packed {
    logic          dn;
    logic          we;
    logic [RW-1:0] rd;
    logic [DW-1:0] res;
    logic          exc;
  } rob_entry_t;

  typedef enum logic {
    RUN,
    FLUSH
  } retire_state_t;

endpackage

// File: rtl/core_retire_unit.sv
// In-order retire stage: pops done ROB entries, commits results to the register file,
// counts retirements and runs a flush handshake when the oldest retirable entry faults.
module core_retire_unit
  import core_retire_unit_pkg::*;
#(
  parameter int RET_W = 1,
  parameter int CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  rob_entry_t [RET_W-1:0]        rob_dat,
  input  logic       [RET_W-1:0][PW-1:0] rob_ptr,
  input  logic       [PW-1:0]           rob_cnt,
  output logic       [RET_W-1:0]        rob_pop,
  output logic       [RET_W-1:0]        rf_we,
  output logic       [RET_W-1:0][RW-1:0] rf_addr,
  output logic       [RET_W-1:0][DW-1:0] rf_dat,
  output logic                          flush_req,
  output logic       [PW-1:0]           flush_ptr,
  input  logic                          flush_ack,
  output logic       [CNT_W-1:0]        ret_cnt
);

  retire_state_t    state;
  logic [RET_W-1:0] pop;
  logic             chain;
  logic             live;
  logic             exc_hit;
  logic [PW-1:0]    exc_ptr;
  logic [CNT_W-1:0] pop_sum;

  // Prefix-AND over slots: the first slot that is not cleanly retirable breaks the
  // chain; if that slot is a done, faulting entry it becomes the flush trigger.
  always_comb begin
    pop     = '0;
    chain   = (state == RUN);
    live    = 1'b0;
    exc_hit = 1'b0;
    exc_ptr = '0;
    pop_sum = '0;
    for (int i = 0; i < RET_W; i++) begin
      live = chain && (i < int'(rob_cnt)) && rob_dat[i].dn;
      if (live && !rob_dat[i].exc) begin
        pop[i] = 1'b1;
      end else begin
        if (live) begin
          exc_hit = 1'b1;
          exc_ptr = rob_ptr[i];
        end
        chain = 1'b0;
      end
      pop_sum = pop_sum + CNT_W'(pop[i]);
    end
  end

  assign rob_pop = rst ? '0 : pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      rf_we     <= '0;
      rf_addr   <= '0;
      rf_dat    <= '0;
      flush_req <= 1'b0;
      flush_ptr <= '0;
      ret_cnt   <= '0;
    end else begin
      for (int i = 0; i < RET_W; i++) begin
        rf_we[i] <= pop[i] & rob_dat[i].we;
        if (pop[i]) begin
          rf_addr[i] <= rob_dat[i].rd;
          rf_dat[i]  <= rob_dat[i].res;
        end
      end
      ret_cnt <= ret_cnt + pop_sum;
      case (state)
        RUN: begin
          if (exc_hit) begin
            state     <= FLUSH;
            flush_req <= 1'b1;
            flush_ptr <= exc_ptr;
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            state     <= RUN;
            flush_req <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_core_retire_unit.sv
// Directed bench for core_retire_unit: a single-wide and a two-wide instance share clock and reset.
module tb_core_retire_unit;
  import core_retire_unit_pkg::*;

  logic clk;
  logic rst;

  rob_entry_t [0:0]         dat1;
  logic [0:0][PW-1:0]       ptr1;
  logic [PW-1:0]            cnt1;
  logic [0:0]               pop1;
  logic [0:0]               we1;
  logic [0:0][RW-1:0]       addr1;
  logic [0:0][DW-1:0]       rfd1;
  logic                     freq1;
  logic [PW-1:0]            fptr1;
  logic                     ack1;
  logic [31:0]              rc1;

  rob_entry_t [1:0]         dat2;
  logic [1:0][PW-1:0]       ptr2;
  logic [PW-1:0]            cnt2;
  logic [1:0]               pop2;
  logic [1:0]               we2;
  logic [1:0][RW-1:0]       addr2;
  logic [1:0][DW-1:0]       rfd2;
  logic                     freq2;
  logic [PW-1:0]            fptr2;
  logic                     ack2;
  logic [31:0]              rc2;

  int total;
  int bad;

  core_retire_unit #(.RET_W(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .rob_dat(dat1), .rob_ptr(ptr1), .rob_cnt(cnt1),
    .rob_pop(pop1), .rf_we(we1), .rf_addr(addr1), .rf_dat(rfd1),
    .flush_req(freq1), .flush_ptr(fptr1), .flush_ack(ack1), .ret_cnt(rc1)
  );

  core_retire_unit #(.RET_W(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .rob_dat(dat2), .rob_ptr(ptr2), .rob_cnt(cnt2),
    .rob_pop(pop2), .rf_we(we2), .rf_addr(addr2), .rf_dat(rfd2),
    .flush_req(freq2), .flush_ptr(fptr2), .flush_ack(ack2), .ret_cnt(rc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rob_entry_t mk(input logic dn, input logic we, input logic [RW-1:0] rd,
                                    input logic [DW-1:0] res, input logic exc);
    rob_entry_t e;
    e.dn  = dn;
    e.we  = we;
    e.rd  = rd;
    e.res = res;
    e.exc = exc;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    cnt1 = '0; ptr1 = '0; ack1 = 1'b0; dat1[0] = mk(1'b0, 1'b0, '0, '0, 1'b0);
    cnt2 = '0; ptr2 = '0; ack2 = 1'b0;
    dat2[0] = mk(1'b0, 1'b0, '0, '0, 1'b0);
    dat2[1] = mk(1'b0, 1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    // Commit one entry so the asynchronous reset has live state to clear.
    dat1[0] = mk(1'b1, 1'b1, 4'd5, 16'h1234, 1'b0);
    cnt1 = 4'd1;
    step();
    total++;
    if (we1 !== 1'b1 || rc1 !== 32'd1) begin
      bad++;
      $display("[TB] FAIL pre_reset_commit: rf_we=%0b ret_cnt=%0d required 1/1", we1, rc1);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (we1 !== 1'b0 || addr1 !== '0 || rfd1 !== '0 || rc1 !== 32'd0 || pop1 !== 1'b0 ||
        freq1 !== 1'b0 || fptr1 !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: we=%0b addr=%0d dat=%h cnt=%0d pop=%0b freq=%0b fptr=%0d required all 0",
               we1, addr1, rfd1, rc1, pop1, freq1, fptr1);
    end
    cnt1 = '0;
    @(negedge clk);
    rst = 1'b0;
    // Entry marked done but count zero: nothing may pop.
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (pop1 !== 1'b0 || we1 !== 1'b0 || rc1 !== 32'd0) begin
        bad++;
        $display("[TB] FAIL idle_empty[%0d]: pop=%0b we=%0b ret_cnt=%0d required 0/0/0", c, pop1, we1, rc1);
      end
    end
  endtask

  task automatic test_single();
    dat1[0] = mk(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0);
    cnt1 = 4'd1;
    #1;
    total++;
    if (pop1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_pop: rob_pop=%0b required 1", pop1);
    end
    step();
    cnt1 = '0;
    total++;
    if (we1 !== 1'b1 || addr1[0] !== 4'd3 || rfd1[0] !== 16'hBEEF || rc1 !== 32'd1) begin
      bad++;
      $display("[TB] FAIL single_commit: we=%0b addr=%0d dat=%h cnt=%0d required 1/3/beef/1",
               we1, addr1[0], rfd1[0], rc1);
    end
    step();
    total++;
    if (we1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_we_drop: rf_we=%0b required 0", we1);
    end
  endtask

  task automatic test_blocking();
    dat1[0] = mk(1'b0, 1'b1, 4'd6, 16'h0A0A, 1'b0);
    cnt1 = 4'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (pop1 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL block_nopop[%0d]: rob_pop=%0b required 0", c, pop1);
      end
      step();
    end
    dat1[0].dn = 1'b1;
    #1;
    total++;
    if (pop1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL block_release: rob_pop=%0b required 1", pop1);
    end
    step();
    cnt1 = '0;
    total++;
    if (rc1 !== 32'd2 || we1 !== 1'b1 || rfd1[0] !== 16'h0A0A) begin
      bad++;
      $display("[TB] FAIL block_commit: ret_cnt=%0d we=%0b dat=%h required 2/1/0a0a", rc1, we1, rfd1[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] we_pat;
    we_pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      dat1[0] = mk(1'b1, we_pat[i], RW'(i + 1), DW'(16'h1000 + i), 1'b0);
      cnt1 = PW'(4 - i);
      #1;
      total++;
      if (pop1 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_pop[%0d]: rob_pop=%0b required 1", i, pop1);
      end
      step();
      total++;
      if (we1 !== we_pat[i] || rfd1[0] !== DW'(16'h1000 + i)) begin
        bad++;
        $display("[TB] FAIL b2b_commit[%0d]: we=%0b dat=%h required %0b/%h", i, we1, rfd1[0],
                 we_pat[i], DW'(16'h1000 + i));
      end
    end
    cnt1 = '0;
    // Cumulative: 2 earlier retirements plus these 4.
    total++;
    if (rc1 !== 32'd6) begin
      bad++;
      $display("[TB] FAIL b2b_count: ret_cnt=%0d required 6", rc1);
    end
  endtask

  task automatic test_exception();
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    total++;
    if (freq1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ack_in_run: flush_req=%0b required 0", freq1);
    end
    dat1[0] = mk(1'b1, 1'b1, 4'd8, 16'hDEAD, 1'b1);
    ptr1[0] = 4'd7;
    cnt1 = 4'd1;
    #1;
    total++;
    if (pop1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL exc_nopop: rob_pop=%0b required 0", pop1);
    end
    step();
    total++;
    if (freq1 !== 1'b1 || fptr1 !== 4'd7 || we1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL exc_flush: freq=%0b fptr=%0d we=%0b required 1/7/0", freq1, fptr1, we1);
    end
    // Clear the fault bit while still flushing: FLUSH alone must hold the pop low.
    dat1[0].exc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (pop1 !== 1'b0 || freq1 !== 1'b1 || we1 !== 1'b0 || rc1 !== 32'd6) begin
        bad++;
        $display("[TB] FAIL flush_hold[%0d]: pop=%0b freq=%0b we=%0b cnt=%0d required 0/1/0/6",
                 c, pop1, freq1, we1, rc1);
      end
      step();
    end
    ack1 = 1'b1;
    cnt1 = '0;
    step();
    ack1 = 1'b0;
    total++;
    if (freq1 !== 1'b0 || we1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_release: freq=%0b we=%0b required 0/0", freq1, we1);
    end
    dat1[0] = mk(1'b1, 1'b1, 4'd9, 16'h55AA, 1'b0);
    cnt1 = 4'd1;
    #1;
    total++;
    if (pop1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL resume_pop: rob_pop=%0b required 1", pop1);
    end
    step();
    cnt1 = '0;
    total++;
    if (we1 !== 1'b1 || addr1[0] !== 4'd9 || rfd1[0] !== 16'h55AA || rc1 !== 32'd7) begin
      bad++;
      $display("[TB] FAIL resume_commit: we=%0b addr=%0d dat=%h cnt=%0d required 1/9/55aa/7",
               we1, addr1[0], rfd1[0], rc1);
    end
  endtask

  task automatic test_wide();
    dat2[0] = mk(1'b1, 1'b1, 4'd1, 16'h0101, 1'b0);
    dat2[1] = mk(1'b0, 1'b1, 4'd2, 16'h0202, 1'b0);
    cnt2 = 4'd2;
    #1;
    total++;
    if (pop2 !== 2'b01) begin
      bad++;
      $display("[TB] FAIL wide_partial: rob_pop=%b required 01", pop2);
    end
    step();
    total++;
    if (we2 !== 2'b01 || rc2 !== 32'd1 || rfd2[0] !== 16'h0101) begin
      bad++;
      $display("[TB] FAIL wide_partial_commit: we=%b cnt=%0d dat0=%h required 01/1/0101", we2, rc2, rfd2[0]);
    end
    dat2[0] = mk(1'b1, 1'b0, 4'd3, 16'h0303, 1'b0);
    dat2[1] = mk(1'b1, 1'b1, 4'd4, 16'h0404, 1'b0);
    cnt2 = 4'd1;
    #1;
    total++;
    if (pop2 !== 2'b01) begin
      bad++;
      $display("[TB] FAIL wide_cnt_limit: rob_pop=%b required 01", pop2);
    end
    cnt2 = 4'd2;
    #1;
    total++;
    if (pop2 !== 2'b11) begin
      bad++;
      $display("[TB] FAIL wide_both: rob_pop=%b required 11", pop2);
    end
    step();
    total++;
    if (we2 !== 2'b10 || rc2 !== 32'd3 || addr2[1] !== 4'd4 || rfd2[1] !== 16'h0404) begin
      bad++;
      $display("[TB] FAIL wide_both_commit: we=%b cnt=%0d addr1=%0d dat1=%h required 10/3/4/0404",
               we2, rc2, addr2[1], rfd2[1]);
    end
    dat2[0] = mk(1'b1, 1'b1, 4'd5, 16'h0505, 1'b0);
    dat2[1] = mk(1'b1, 1'b1, 4'd6, 16'hBAD0, 1'b1);
    ptr2[0] = 4'd10;
    ptr2[1] = 4'd11;
    #1;
    total++;
    if (pop2 !== 2'b01) begin
      bad++;
      $display("[TB] FAIL wide_exc_pop: rob_pop=%b required 01", pop2);
    end
    step();
    total++;
    if (freq2 !== 1'b1 || fptr2 !== 4'd11 || we2 !== 2'b01 || rc2 !== 32'd4 || rfd2[0] !== 16'h0505) begin
      bad++;
      $display("[TB] FAIL wide_exc_flush: freq=%0b fptr=%0d we=%b cnt=%0d dat0=%h required 1/11/01/4/0505",
               freq2, fptr2, we2, rc2, rfd2[0]);
    end
    #1;
    total++;
    if (pop2 !== 2'b00) begin
      bad++;
      $display("[TB] FAIL wide_flush_nopop: rob_pop=%b required 00", pop2);
    end
    ack2 = 1'b1;
    cnt2 = '0;
    step();
    ack2 = 1'b0;
    total++;
    if (freq2 !== 1'b0 || we2 !== 2'b00) begin
      bad++;
      $display("[TB] FAIL wide_release: freq=%0b we=%b required 0/00", freq2, we2);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_blocking();
    test_back_to_back();
    test_exception();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
